// File: rtl/dispense_controller_if.sv
// Handshake bundle between the button/sensor front end and the dispense controller.
// The master side drives button pulses and sensor levels; the slave side (the
// controller) drives valve and status outputs.
interface dispense_controller_if;
    logic       size_pressed;
    logic       start_pressed;
    logic       cancel_pressed;
    logic       cup_present;
    logic       tank_empty;
    logic       valve_open;
    logic [1:0] selected_size;
    logic [7:0] units_remaining;
    logic       done;
    logic       fault;

    modport master (
        output size_pressed, start_pressed, cancel_pressed, cup_present, tank_empty,
        input  valve_open, selected_size, units_remaining, done, fault
    );

    modport slave (
        input  size_pressed, start_pressed, cancel_pressed, cup_present, tank_empty,
        output valve_open, selected_size, units_remaining, done, fault
    );
endinterface

// File: rtl/dispense_controller.sv
// Water dispenser main control FSM: selects cup size, runs the valve for a
// size-dependent number of timed volume units, and reports done/fault status.
module dispense_controller #(
    parameter int TICKS_PER_UNIT = 50000000,
    parameter int SMALL_UNITS    = 2,
    parameter int MEDIUM_UNITS   = 4,
    parameter int LARGE_UNITS    = 6,
    parameter int DONE_CYCLES    = 100000000
) (
    input  logic                  clock,
    input  logic                  reset,
    dispense_controller_if.slave  bus
);

    // Counter widths sized so the terminal value always fits; a width of at
    // least one bit keeps the degenerate parameter value 1 legal.
    localparam int TICK_W = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
    localparam int DONE_W = (DONE_CYCLES > 1) ? $clog2(DONE_CYCLES) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_UNIT - 1);
    localparam logic [DONE_W-1:0] DONE_LAST = DONE_W'(DONE_CYCLES - 1);

    localparam logic [7:0] SMALL_LOAD  = 8'(SMALL_UNITS);
    localparam logic [7:0] MEDIUM_LOAD = 8'(MEDIUM_UNITS);
    localparam logic [7:0] LARGE_LOAD  = 8'(LARGE_UNITS);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DISPENSING = 2'd1,
        DONE       = 2'd2,
        FAULT      = 2'd3
    } state_t;

    state_t              state;
    logic [TICK_W-1:0]   tick_count;
    logic [DONE_W-1:0]   done_count;
    logic [7:0]          fill_units;

    // Volume to load for the currently selected cup size.
    always_comb begin
        fill_units = SMALL_LOAD;
        case (bus.selected_size)
            2'd1:    fill_units = MEDIUM_LOAD;
            2'd2:    fill_units = LARGE_LOAD;
            default: fill_units = SMALL_LOAD;
        endcase
    end

    // Main FSM; every output is a register updated alongside the state so the
    // valve/done/fault flags track the state exactly, and reset closes the
    // valve without waiting for a clock edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state               <= IDLE;
            tick_count          <= '0;
            done_count          <= '0;
            bus.valve_open      <= 1'b0;
            bus.selected_size   <= 2'd0;
            bus.units_remaining <= 8'd0;
            bus.done            <= 1'b0;
            bus.fault           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start_pressed && bus.tank_empty) begin
                        state     <= FAULT;
                        bus.fault <= 1'b1;
                    end else if (bus.start_pressed && bus.cup_present) begin
                        state               <= DISPENSING;
                        tick_count          <= '0;
                        bus.units_remaining <= fill_units;
                        bus.valve_open      <= 1'b1;
                    end else if (bus.size_pressed && !bus.start_pressed) begin
                        // A start pulse in the same cycle suppresses the size
                        // advance even when the start itself is ignored.
                        bus.selected_size <= (bus.selected_size == 2'd2) ? 2'd0
                                                                         : bus.selected_size + 2'd1;
                    end
                end

                DISPENSING: begin
                    if (bus.tank_empty) begin
                        state          <= FAULT;
                        bus.valve_open <= 1'b0;
                        bus.fault      <= 1'b1;
                    end else if (bus.cancel_pressed || !bus.cup_present) begin
                        // Aborted fill: leave the remaining count visible.
                        state          <= IDLE;
                        bus.valve_open <= 1'b0;
                    end else if (tick_count == TICK_LAST) begin
                        tick_count          <= '0;
                        bus.units_remaining <= bus.units_remaining - 8'd1;
                        if (bus.units_remaining == 8'd1) begin
                            state          <= DONE;
                            done_count     <= '0;
                            bus.valve_open <= 1'b0;
                            bus.done       <= 1'b1;
                        end
                    end else begin
                        tick_count <= tick_count + 1'b1;
                    end
                end

                DONE: begin
                    if (bus.cancel_pressed || done_count == DONE_LAST) begin
                        state      <= IDLE;
                        done_count <= '0;
                        bus.done   <= 1'b0;
                    end else begin
                        done_count <= done_count + 1'b1;
                    end
                end

                FAULT: begin
                    if (bus.cancel_pressed && !bus.tank_empty) begin
                        state     <= IDLE;
                        bus.fault <= 1'b0;
                    end
                end

                default: begin
                    state          <= IDLE;
                    bus.valve_open <= 1'b0;
                    bus.done       <= 1'b0;
                    bus.fault      <= 1'b0;
                end
            endcase
        end
    end

endmodule
